// File: rtl/ps2_cmd_pkg.sv
// Shared scan-code constants, receiver state encoding and frame geometry
// for the PS/2 keyboard command front end.
package ps2_cmd_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;
  localparam logic [7:0] SC_UP  = 8'h75;
  localparam logic [7:0] SC_DN  = 8'h72;
  localparam logic [7:0] SC_RT  = 8'h74;
  localparam logic [7:0] SC_LT  = 8'h6B;
  localparam logic [7:0] SC_ESC = 8'h76;
  localparam logic [7:0] SC_F   = 8'h2B;
  localparam logic [7:0] SC_Q   = 8'h15;
  localparam logic [7:0] SC_H   = 8'h33;

  // start + 8 data + parity + stop
  localparam int FRAME_LEN = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } rx_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 byte receiver: input synchronizers, clock glitch filter, falling-edge
// detect, 11-bit frame capture with start/stop/parity check and a watchdog.
module ps2_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ps2c_i,
  input  logic       ps2d_i,
  output logic [7:0] rx_byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o
);
  import ps2_cmd_pkg::*;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  logic          c_meta_q, c_sync_q, d_meta_q, d_sync_q;
  logic          filt_q, filt_prev_q;
  logic [FW-1:0] fcnt_q;
  rx_state_e     state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [10:0]   sh_q, sh_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          fall, wd_expired, frame_ok;

  // Synchronizers reset to the idle-high line level so reset never fakes an edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      c_meta_q    <= 1'b1;
      c_sync_q    <= 1'b1;
      d_meta_q    <= 1'b1;
      d_sync_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      fcnt_q      <= '0;
    end else begin
      c_meta_q    <= ps2c_i;
      c_sync_q    <= c_meta_q;
      d_meta_q    <= ps2d_i;
      d_sync_q    <= d_meta_q;
      filt_prev_q <= filt_q;
      if (c_sync_q == filt_q) begin
        fcnt_q <= '0;
      end else if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_q <= c_sync_q;
        fcnt_q <= '0;
      end else begin
        fcnt_q <= fcnt_q + 1'b1;
      end
    end
  end

  assign fall       = filt_prev_q & ~filt_q;
  assign wd_expired = (wd_q == WW'(TIMEOUT - 1));

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    wd_d      = '0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d   = SHIFT;
          bit_cnt_d = 4'd1;
          sh_d      = {d_sync_q, sh_q[10:1]};
        end
      end
      SHIFT: begin
        if (fall) begin
          sh_d = {d_sync_q, sh_q[10:1]};
          if (bit_cnt_q == 4'(FRAME_LEN - 1)) state_d = CHECK;
          else bit_cnt_d = bit_cnt_q + 1'b1;
        end else if (wd_expired) begin
          state_d = IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      sh_q      <= '0;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sh_q      <= sh_d;
      wd_q      <= wd_d;
    end
  end

  // sh_q[0] = start, sh_q[8:1] = d0..d7, sh_q[9] = parity, sh_q[10] = stop
  assign frame_ok     = ~sh_q[0] & sh_q[10] & (^sh_q[9:1]);
  assign rx_byte_o    = sh_q[8:1];
  assign byte_valid_o = (state_q == CHECK) & frame_ok;
  assign frame_err_o  = ((state_q == CHECK) & ~frame_ok) |
                        ((state_q == SHIFT) & ~fall & wd_expired);

endmodule

// File: rtl/ps2_cmd_decoder.sv
// Keyboard command decoder: tracks E0/F0 prefixes and per-key held bits, and
// turns scan-code makes into the clock/alarm command strobes and levels.
module ps2_cmd_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 100000,
  parameter int RST_HOLD   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2d,
  input  logic ps2c,
  output logic Aumenta,
  output logic Disminuye,
  output logic Siguiente,
  output logic Anterior,
  output logic Reset,
  output logic Formato,
  output logic QuitarAlarma,
  output logic CambiarHora,
  output logic frame_err
);
  import ps2_cmd_pkg::*;

  localparam int RW = $clog2(RST_HOLD + 1);
  localparam int P_UP = 0, P_DN = 1, P_RT = 2, P_LT = 3, P_Q = 4, P_H = 5;
  localparam int K_ESC = 0, K_F = 1, K_Q = 2, K_H = 3;

  logic [7:0]    rx_byte;
  logic          byte_valid;
  logic          ext_q, ext_d, brk_q, brk_d, fmt_q, fmt_d;
  logic [3:0]    held_q, held_d;
  logic [5:0]    pulse_q, pulse_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk_i        (clk),
    .rst_ni       (reset),
    .ps2c_i       (ps2c),
    .ps2d_i       (ps2d),
    .rx_byte_o    (rx_byte),
    .byte_valid_o (byte_valid),
    .frame_err_o  (frame_err)
  );

  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    held_d  = held_q;
    fmt_d   = fmt_q;
    pulse_d = '0;
    rcnt_d  = (rcnt_q != '0) ? rcnt_q - 1'b1 : '0;
    if (byte_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        if (brk_q) begin
          // Release: only the non-extended keys keep a held bit
          if (!ext_q) begin
            case (rx_byte)
              SC_ESC:  held_d[K_ESC] = 1'b0;
              SC_F:    held_d[K_F]   = 1'b0;
              SC_Q:    held_d[K_Q]   = 1'b0;
              SC_H:    held_d[K_H]   = 1'b0;
              default: ;
            endcase
          end
        end else if (ext_q) begin
          case (rx_byte)
            SC_UP:   pulse_d[P_UP] = 1'b1;
            SC_DN:   pulse_d[P_DN] = 1'b1;
            SC_RT:   pulse_d[P_RT] = 1'b1;
            SC_LT:   pulse_d[P_LT] = 1'b1;
            default: ;
          endcase
        end else begin
          // Typematic repeats are swallowed until the key is released
          case (rx_byte)
            SC_ESC: if (!held_q[K_ESC]) begin
              held_d[K_ESC] = 1'b1;
              rcnt_d        = RW'(RST_HOLD);
            end
            SC_F: if (!held_q[K_F]) begin
              held_d[K_F] = 1'b1;
              fmt_d       = ~fmt_q;
            end
            SC_Q: if (!held_q[K_Q]) begin
              held_d[K_Q] = 1'b1;
              pulse_d[P_Q] = 1'b1;
            end
            SC_H: if (!held_q[K_H]) begin
              held_d[K_H] = 1'b1;
              pulse_d[P_H] = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      held_q  <= '0;
      fmt_q   <= 1'b0;
      pulse_q <= '0;
      rcnt_q  <= '0;
    end else begin
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      held_q  <= held_d;
      fmt_q   <= fmt_d;
      pulse_q <= pulse_d;
      rcnt_q  <= rcnt_d;
    end
  end

  assign Aumenta      = pulse_q[P_UP];
  assign Disminuye    = pulse_q[P_DN];
  assign Siguiente    = pulse_q[P_RT];
  assign Anterior     = pulse_q[P_LT];
  assign QuitarAlarma = pulse_q[P_Q];
  assign CambiarHora  = pulse_q[P_H];
  assign Formato      = fmt_q;
  assign Reset        = (rcnt_q != '0);

endmodule
